// File: rtl/jtframe_mister_ddr_upld.sv
// Core-to-DDRAM uploader: packs core bytes little-endian into 64-bit words,
// buffers one burst in block RAM and writes it to the HPS window as Avalon bursts.
module jtframe_mister_ddr_upld #(
    parameter int         BW   = 7,
    parameter logic [3:0] BASE = 4'd3
)(
    input  logic        rst,
    input  logic        clk,
    input  logic        start,
    input  logic        flush,
    input  logic [7:0]  din,
    input  logic        din_we,
    output logic        din_rdy,
    output logic        busy,
    output logic        done,
    output logic [26:0] byte_cnt,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we
);

    localparam int PW    = 25 - BW;
    localparam int DEPTH = 1 << BW;

    typedef enum logic [2:0] {IDLE, FILL, PRE, WRITE, FIN} state_t;

    state_t        state, next_state;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   pack, pack_next;
    logic [PW-1:0] page;
    logic [BW:0]   beat, burst_len, flush_len;
    logic [7:0]    last_be, part_be;
    logic          last_burst;
    logic          accept, full, beat_ok, final_beat, wr_en;
    logic [2:0]    lane;
    logic [BW+3:0] eff;
    logic [26:0]   byte_cnt_inc;

    assign lane         = byte_cnt[2:0];
    assign accept       = din_we && din_rdy && state == FILL;
    assign full         = accept && (&byte_cnt[BW+2:0]);
    // Bytes pending in this burst once a byte arriving with flush is counted
    assign eff          = {1'b0, byte_cnt[BW+2:0]} + (BW+4)'(accept);
    assign flush_len    = eff[BW+3:3] + (BW+1)'(eff[2:0] != 3'd0);
    assign part_be      = (eff[2:0] == 3'd0) ? 8'hFF : ((8'd1 << eff[2:0]) - 8'd1);
    assign beat_ok      = ddram_we && !ddram_busy;
    assign final_beat   = beat == burst_len;
    assign wr_en        = (accept && lane == 3'd7) ||
                          (state == FILL && flush && eff[2:0] != 3'd0);
    assign byte_cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + 27'd1;
    assign ddram_addr   = {BASE, page, {BW{1'b0}}};

    // NOTE: combinational blocks assign every output a default first so no
    // path through them can leave a value held, which would infer a latch.
    always_comb begin
        pack_next = pack;
        if (accept) pack_next[{lane, 3'b000} +: 8] = din;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FILL;
            FILL: begin
                if (flush)     next_state = (eff == '0) ? FIN : PRE;
                else if (full) next_state = PRE;
            end
            PRE:   next_state = WRITE;
            WRITE: if (beat_ok && final_beat) next_state = last_burst ? FIN : FILL;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the burst buffer has no reset so it maps onto block RAM; stale
    // entries are never read because the counters addressing it are reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[byte_cnt[BW+2:3]] <= pack_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            din_rdy        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            byte_cnt       <= '0;
            pack           <= '0;
            page           <= '0;
            beat           <= '0;
            burst_len      <= '0;
            last_be        <= '0;
            last_burst     <= 1'b0;
            ddram_burstcnt <= '0;
            ddram_din      <= '0;
            ddram_be       <= '0;
            ddram_we       <= 1'b0;
        end else begin
            state   <= next_state;
            din_rdy <= next_state == FILL;
            busy    <= next_state != IDLE;
            done    <= next_state == FIN;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt   <= '0;
                        pack       <= '0;
                        page       <= '0;
                        last_burst <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt_inc;
                        pack     <= (lane == 3'd7) ? '0 : pack_next;
                    end
                    if (flush) begin
                        pack       <= '0;
                        burst_len  <= flush_len;
                        last_be    <= part_be;
                        last_burst <= 1'b1;
                    end else if (full) begin
                        burst_len  <= (BW+1)'(DEPTH);
                        last_be    <= 8'hFF;
                        last_burst <= 1'b0;
                    end
                end
                PRE: begin
                    // Buffer read for beat 0 lands straight in the output register
                    ddram_burstcnt <= 8'(burst_len);
                    ddram_din      <= mem[0];
                    ddram_be       <= (burst_len == (BW+1)'(1)) ? last_be : 8'hFF;
                    ddram_we       <= 1'b1;
                    beat           <= (BW+1)'(1);
                end
                WRITE: begin
                    if (beat_ok) begin
                        if (final_beat) begin
                            ddram_we <= 1'b0;
                            page     <= page + PW'(1);
                        end else begin
                            ddram_din <= mem[beat[BW-1:0]];
                            ddram_be  <= (beat == burst_len - (BW+1)'(1)) ? last_be : 8'hFF;
                            beat      <= beat + (BW+1)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_mister_ddr_upld.sv
// Self-checking bench for jtframe_mister_ddr_upld: session vector table plus a
// beat scoreboard filled from a byte-level model of the DDRAM contents.
`timescale 1ns/1ps
module tb_jtframe_mister_ddr_upld;

    logic        rst, clk, start, flush, din_we, din_rdy, busy, done;
    logic        ddram_busy, ddram_we;
    logic [7:0]  din, ddram_burstcnt, ddram_be;
    logic [26:0] byte_cnt;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;

    jtframe_mister_ddr_upld #(.BW(7), .BASE(4'd3)) dut (
        .rst(rst), .clk(clk), .start(start), .flush(flush), .din(din),
        .din_we(din_we), .din_rdy(din_rdy), .busy(busy), .done(done),
        .byte_cnt(byte_cnt), .ddram_busy(ddram_busy),
        .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr),
        .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_we(ddram_we)
    );

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  bc;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    typedef struct {
        int         nbytes;
        int         seed;
        bit         do_flush;
        bit         coincide;
        bit         stall;
        bit         chk_lat;
        int         exp_beats;
        int         exp_done;
        logic [7:0] exp_last_bc;
        logic [7:0] exp_last_be;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[9];

    int chk_cnt = 0, pass_cnt = 0;
    int cyc = 0;
    bit abort = 0;
    bit stall_en = 0;

    logic [7:0] mb[1024];
    int mb_n, m_page;
    bit m_flush_burst;
    int trig_cyc;

    int total_beats = 0, sess_base = 0, last_beat_cyc = 0, first_we_cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    logic [63:0] first_din;
    logic [28:0] first_addr;
    logic [7:0]  last_be_seen, last_bc_seen;
    logic        prev_stall, prev_we;
    logic [72:0] prev_hold;
    beat_t       mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        chk_cnt++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
        else pass_cnt++;
    endtask

    task automatic fail(input string name);
        chk_cnt++;
        $display("FAIL %s: condition not reached", name);
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) m[k*8 +: 8] = be[k] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Model: bytes of the open burst, emitted as expected DDRAM beats on close
    task automatic close_burst();
        int nw;
        beat_t b;
        nw = (mb_n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            b.addr = {4'd3, 18'(m_page), 7'd0};
            b.bc   = 8'(nw);
            b.data = '0;
            b.be   = '0;
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < mb_n) begin
                    b.data[k*8 +: 8] = mb[w*8+k];
                    b.be[k] = 1'b1;
                end
            end
            sb.push_back(b);
        end
        m_page++;
        mb_n = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        mb[mb_n] = b;
        mb_n++;
        if (mb_n == 1024) close_burst();
    endtask

    task automatic model_flush();
        m_flush_burst = (mb_n > 0);
        if (mb_n > 0) close_burst();
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!din_rdy && !abort && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!din_rdy && !abort) begin
            fail("din_rdy_timeout");
            abort = 1;
        end
    endtask

    task automatic drive_bytes(input int n, input int seed, input bit coincide);
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            wait_rdy();
            din = 8'(i + seed);
            din_we = 1'b1;
            model_byte(din);
            trig_cyc = cyc;
            if (coincide && i == n - 1) begin
                flush = 1'b1;
                model_flush();
            end
            @(posedge clk); #1;
            din_we = 1'b0;
            flush = 1'b0;
        end
    endtask

    task automatic open_session(input bit stall);
        sess_base = total_beats;
        mb_n = 0;
        m_page = 0;
        m_flush_burst = 0;
        stall_en = stall;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int base_done, wc;
        base_done = done_cnt;
        open_session(v.stall);
        drive_bytes(v.nbytes, v.seed, v.coincide);
        if (v.do_flush && !v.coincide) begin
            wait_rdy();
            flush = 1'b1;
            model_flush();
            trig_cyc = cyc;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        wc = 0;
        while ((sb.size() != 0 || ddram_we || (v.do_flush && busy)) && wc < 3000) begin
            @(posedge clk); #1;
            wc++;
        end
        if (wc >= 3000) fail("drain_timeout");
        stall_en = 0;
        check("beat_count", 128'(total_beats - sess_base), 128'(v.exp_beats));
        check("byte_cnt", 128'(byte_cnt), 128'(v.nbytes));
        check("done_count", 128'(done_cnt - base_done), 128'(v.exp_done));
        if (v.exp_beats > 0) begin
            check("last_burstcnt", 128'(last_bc_seen), 128'(v.exp_last_bc));
            check("last_be", 128'(last_be_seen), 128'(v.exp_last_be));
        end
        if (v.chk_lat) check("we_latency", 128'(first_we_cyc - trig_cyc), 128'(2));
        if (v.do_flush) begin
            check("busy_after_done", 128'(busy), 128'(0));
            check("din_rdy_after_done", 128'(din_rdy), 128'(0));
            if (m_flush_burst) check("done_after_beat", 128'(done_cyc - last_beat_cyc), 128'(1));
            else               check("done_after_flush", 128'(done_cyc - trig_cyc), 128'(1));
        end else begin
            check("din_rdy_return", 128'(din_rdy), 128'(1));
            check("rdy_after_beat", 128'(cyc - last_beat_cyc), 128'(1));
            check("busy_open", 128'(busy), 128'(1));
        end
    endtask

    task automatic check_reset_vals();
        check("rst_din_rdy", 128'(din_rdy), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_byte_cnt", 128'(byte_cnt), 128'(0));
        check("rst_we", 128'(ddram_we), 128'(0));
        check("rst_burstcnt", 128'(ddram_burstcnt), 128'(0));
        check("rst_be", 128'(ddram_be), 128'(0));
        check("rst_din", 128'(ddram_din), 128'(0));
        check("rst_addr", 128'(ddram_addr), 128'(29'h6000000));
    endtask

    // Avalon waitrequest: toggles every cycle while stalling is enabled
    initial begin
        ddram_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            ddram_busy = stall_en ? ~ddram_busy : 1'b0;
        end
    end

    // Beat monitor and scoreboard consumer
    initial begin
        prev_stall = 1'b0;
        prev_we = 1'b0;
        prev_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_we = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 128'({ddram_we, ddram_be, ddram_din}), 128'(prev_hold));
                if (ddram_we && !prev_we) first_we_cyc = cyc;
                if (ddram_we && !ddram_busy) begin
                    if (sb.size() == 0) fail("unexpected_beat");
                    else begin
                        mon_e = sb.pop_front();
                        check("beat_addr", 128'(ddram_addr), 128'(mon_e.addr));
                        check("beat_burstcnt", 128'(ddram_burstcnt), 128'(mon_e.bc));
                        check("beat_be", 128'(ddram_be), 128'(mon_e.be));
                        check("beat_data", 128'(ddram_din & be_mask(mon_e.be)), 128'(mon_e.data));
                    end
                    if (total_beats == sess_base) begin
                        first_din = ddram_din;
                        first_addr = ddram_addr;
                    end
                    total_beats++;
                    last_beat_cyc = cyc;
                    last_be_seen = ddram_be;
                    last_bc_seen = ddram_burstcnt;
                end
                prev_stall = ddram_we && ddram_busy;
                prev_hold = {ddram_we, ddram_be, ddram_din};
                prev_we = ddram_we;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        vecs[0] = '{nbytes:1024, seed:0,    do_flush:0, coincide:0, stall:0, chk_lat:1,
                    exp_beats:128, exp_done:0, exp_last_bc:8'd128, exp_last_be:8'hFF};
        vecs[1] = '{nbytes:13,   seed:16,   do_flush:1, coincide:0, stall:0, chk_lat:1,
                    exp_beats:2,   exp_done:1, exp_last_bc:8'd2,   exp_last_be:8'h1F};
        vecs[2] = '{nbytes:2048, seed:3,    do_flush:1, coincide:0, stall:0, chk_lat:0,
                    exp_beats:256, exp_done:1, exp_last_bc:8'd128, exp_last_be:8'hFF};
        vecs[3] = '{nbytes:1024, seed:85,   do_flush:1, coincide:0, stall:1, chk_lat:0,
                    exp_beats:128, exp_done:1, exp_last_bc:8'd128, exp_last_be:8'hFF};
        vecs[4] = '{nbytes:0,    seed:0,    do_flush:1, coincide:0, stall:0, chk_lat:0,
                    exp_beats:0,   exp_done:1, exp_last_bc:8'd0,   exp_last_be:8'h00};
        vecs[5] = '{nbytes:1,    seed:170,  do_flush:1, coincide:1, stall:0, chk_lat:1,
                    exp_beats:1,   exp_done:1, exp_last_bc:8'd1,   exp_last_be:8'h01};
        vecs[6] = '{nbytes:1027, seed:7,    do_flush:1, coincide:0, stall:0, chk_lat:0,
                    exp_beats:129, exp_done:1, exp_last_bc:8'd1,   exp_last_be:8'h07};
        vecs[7] = '{nbytes:8,    seed:32,   do_flush:1, coincide:1, stall:0, chk_lat:0,
                    exp_beats:1,   exp_done:1, exp_last_bc:8'd1,   exp_last_be:8'hFF};
        vecs[8] = '{nbytes:13,   seed:64,   do_flush:1, coincide:0, stall:0, chk_lat:0,
                    exp_beats:2,   exp_done:1, exp_last_bc:8'd2,   exp_last_be:8'h1F};

        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        din = '0;
        din_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                check("beat0_din", 128'(first_din), 128'(64'h0706050403020100));
                check("beat0_addr", 128'(first_addr), 128'(29'h6000000));
                rst = 1'b1;
                #1;
                check_reset_vals();
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of a burst, then a fresh session from page 0
        open_session(1'b0);
        drive_bytes(1024, 0, 1'b0);
        wc = 0;
        while (total_beats - sess_base < 40 && wc < 3000) begin
            @(negedge clk);
            wc++;
        end
        if (wc >= 3000) fail("beat40_timeout");
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[8]);
        check("restart_page0", 128'(first_addr), 128'(29'h6000000));

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
